// File: rtl/pkt_arbiter_nto1.sv
// N-input packet-atomic round-robin arbiter with per-input show-ahead FIFOs,
// early-warning ready, registered output gated by a one-cycle-delayed ready.
module pkt_arbiter_nto1 #(
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned NOC_WIDTH   = 600,
  parameter int unsigned SEGMENTS    = 4,
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter int unsigned READY_SLACK = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_IN*NOC_WIDTH-1:0] i_data_in,
  input  logic [NUM_IN-1:0]           i_valid_in,
  output logic [NUM_IN-1:0]           i_ready_out,
  input  logic [NUM_IN-1:0]           i_port_en,
  output logic [NOC_WIDTH-1:0]        o_data_out,
  output logic                        o_valid_out,
  output logic [NUM_IN-1:0]           o_grant,
  input  logic                        o_ready_in,
  output logic [NUM_IN-1:0]           o_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned UW = AW + 1;
  localparam int unsigned PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned SW = NOC_WIDTH / SEGMENTS;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  // Reset asserts asynchronously, releases two edges after reset_n rises.
  logic [1:0] rst_sync;
  logic       rst_i_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  logic [NOC_WIDTH-1:0] mem    [NUM_IN][FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr [NUM_IN];
  logic [AW-1:0]        rd_ptr [NUM_IN];
  logic [UW-1:0]        used   [NUM_IN];
  logic [NOC_WIDTH-1:0] head   [NUM_IN];
  logic [NUM_IN-1:0]    empty, full, push_ok, pop_vec;

  state_t               state, state_nx;
  logic [PW-1:0]        rr_ptr, rr_nx, locked_port, locked_nx;
  logic [PW-1:0]        cand, sel, sel_next;
  logic                 found, avail, load, sel_eop, ready_r;
  logic [NOC_WIDTH-1:0] sel_flit;
  int unsigned          scan_idx;

  function automatic logic is_eop(input logic [NOC_WIDTH-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned s = 0; s < SEGMENTS; s++) begin
      if (f[(s+1)*SW-1] && f[(s+1)*SW-3]) r = 1'b1;
    end
    return r;
  endfunction

  for (genvar p = 0; p < NUM_IN; p++) begin : g_port
    assign head[p]        = mem[p][rd_ptr[p]];
    assign empty[p]       = (used[p] == '0);
    assign full[p]        = (used[p] == UW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok[p]     = i_valid_in[p] && (!full[p] || pop_vec[p]);
    assign i_ready_out[p] = rst_i_n &&
                            ((UW'(FIFO_DEPTH) - used[p]) > UW'(READY_SLACK));
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_IN; p++) begin
      if (push_ok[p]) mem[p][wr_ptr[p]] <= i_data_in[p*NOC_WIDTH +: NOC_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      for (int unsigned p = 0; p < NUM_IN; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        used[p]   <= '0;
      end
      o_overflow <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_IN; p++) begin
        if (push_ok[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
        if (pop_vec[p]) rd_ptr[p] <= rd_ptr[p] + AW'(1);
        case ({push_ok[p], pop_vec[p]})
          2'b10:   used[p] <= used[p] + UW'(1);
          2'b01:   used[p] <= used[p] - UW'(1);
          default: used[p] <= used[p];
        endcase
        if (i_valid_in[p] && full[p] && !pop_vec[p]) o_overflow[p] <= 1'b1;
      end
    end
  end

  always_comb begin
    found    = 1'b0;
    cand     = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      scan_idx = 32'(rr_ptr) + i;
      if (scan_idx >= NUM_IN) scan_idx = scan_idx - NUM_IN;
      if (!found && !empty[scan_idx] && i_port_en[scan_idx]) begin
        found = 1'b1;
        cand  = PW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rr_nx     = rr_ptr;
    locked_nx = locked_port;
    pop_vec   = '0;
    load      = 1'b0;
    sel       = (state == ST_LOCKED) ? locked_port : cand;
    avail     = (state == ST_LOCKED) ? !empty[sel] : found;
    sel_flit  = head[sel];
    sel_eop   = is_eop(sel_flit);
    sel_next  = (sel == PW'(NUM_IN - 1)) ? '0 : sel + PW'(1);
    if (ready_r && avail) begin
      load         = 1'b1;
      pop_vec[sel] = 1'b1;
      if (sel_eop) begin
        rr_nx    = sel_next;
        state_nx = ST_IDLE;
      end else begin
        locked_nx = sel;
        state_nx  = ST_LOCKED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      locked_port <= '0;
      ready_r     <= 1'b0;
      o_valid_out <= 1'b0;
      o_data_out  <= '0;
      o_grant     <= '0;
    end else begin
      state       <= state_nx;
      rr_ptr      <= rr_nx;
      locked_port <= locked_nx;
      ready_r     <= o_ready_in;
      o_valid_out <= load;
      if (load) begin
        o_data_out <= sel_flit;
        o_grant    <= NUM_IN'(1) << sel;
      end else begin
        o_grant    <= '0;
      end
    end
  end

endmodule
